sdram_init: RTL and testbench



---
 rtl/sdram_pkg.sv | 48 ++++
 rtl/sdram_init_if.sv | 18 +
 rtl/sdram_nop_timer.sv | 21 ++
 rtl/sdram_init.sv | 100 ++++++++++
 tb/tb_sdram_init.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, default timing, mode-register fields.
// Imported by the init, write and read stages.
package sdram_pkg;

    typedef logic [3:0] sdram_cmd_t;  // {CS_N, RAS_N, CAS_N, WE_N}

    localparam sdram_cmd_t CMD_NOP       = 4'b0111;
    localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
    localparam sdram_cmd_t CMD_READ      = 4'b0101;
    localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
    localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
    localparam sdram_cmd_t CMD_REFRESH   = 4'b0001;
    localparam sdram_cmd_t CMD_LOAD_MODE = 4'b0000;

    localparam int DEF_POWERUP_CYCLES = 5000;  // 100 us at 50 MHz
    localparam int DEF_TRP_CYCLES     = 2;
    localparam int DEF_TRFC_CYCLES    = 7;
    localparam int DEF_REFRESH_COUNT  = 2;
    localparam int DEF_TMRD_CYCLES    = 2;

    localparam logic [12:0] PRECHARGE_ALL_ADDR = 13'h0400;  // A10 selects all banks

    localparam logic [2:0] MR_BL_1      = 3'b000;
    localparam logic       MR_BT_SEQ    = 1'b0;
    localparam logic [2:0] MR_CL_2      = 3'b010;
    localparam logic [2:0] MR_CL_3      = 3'b011;
    localparam logic       MR_WB_BURST  = 1'b0;
    localparam logic       MR_WB_SINGLE = 1'b1;

    function automatic logic [12:0] mode_word(input logic [2:0] bl, input logic bt,
                                              input logic [2:0] cl, input logic wb);
        return {3'b000, wb, 2'b00, cl, bt, bl};
    endfunction

    localparam logic [12:0] DEF_MODE_REG = mode_word(MR_BL_1, MR_BT_SEQ, MR_CL_2, MR_WB_SINGLE);

    typedef enum logic [7:0] {
        ST_WAIT      = 8'b0000_0001,
        ST_PRECHARGE = 8'b0000_0010,
        ST_TRP       = 8'b0000_0100,
        ST_REFRESH   = 8'b0000_1000,
        ST_TRFC      = 8'b0001_0000,
        ST_LOAD      = 8'b0010_0000,
        ST_TMRD      = 8'b0100_0000,
        ST_DONE      = 8'b1000_0000
    } init_state_t;

endpackage

// File: rtl/sdram_init_if.sv
// SDRAM command/address pins as seen by one sequencing stage.
interface sdram_init_if;
    logic        DRAM_CLK;
    logic        DRAM_CKE;
    logic [12:0] DRAM_ADDR;
    logic [1:0]  DRAM_BA;
    logic        DRAM_CS_N;
    logic        DRAM_RAS_N;
    logic        DRAM_CAS_N;
    logic        DRAM_WE_N;
    logic        DRAM_LDQM;
    logic        DRAM_UDQM;

    modport master (output DRAM_CLK, DRAM_CKE, DRAM_ADDR, DRAM_BA, DRAM_CS_N, DRAM_RAS_N,
                           DRAM_CAS_N, DRAM_WE_N, DRAM_LDQM, DRAM_UDQM);
    modport slave  (input  DRAM_CLK, DRAM_CKE, DRAM_ADDR, DRAM_BA, DRAM_CS_N, DRAM_RAS_N,
                           DRAM_CAS_N, DRAM_WE_N, DRAM_LDQM, DRAM_UDQM);
endinterface

// File: rtl/sdram_nop_timer.sv
// Loadable down-counter; odone is high while the count sits at zero, so a
// caller that reloads on every done sees it for exactly one cycle per load.
module sdram_nop_timer #(
    parameter int WIDTH = 4
) (
    input  logic             iclk,
    input  logic             iload,
    input  logic [WIDTH-1:0] iload_val,
    output logic             odone
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge iclk) begin
        if (iload)
            count <= iload_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign odone = (count == '0);
endmodule

// File: rtl/sdram_init.sv
// SDRAM power-up sequencer: wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE, done.
// Moore one-hot FSM; bus outputs decode from the current state only.
module sdram_init
    import sdram_pkg::*;
#(
    parameter int          POWERUP_CYCLES = DEF_POWERUP_CYCLES,
    parameter int          TRP_CYCLES     = DEF_TRP_CYCLES,
    parameter int          TRFC_CYCLES    = DEF_TRFC_CYCLES,
    parameter int          REFRESH_COUNT  = DEF_REFRESH_COUNT,
    parameter int          TMRD_CYCLES    = DEF_TMRD_CYCLES,
    parameter logic [12:0] MODE_REG       = DEF_MODE_REG
) (
    input  logic         iclk,
    input  logic         ireset,
    output logic         oinit_fin,
    sdram_init_if.master dram
);
    localparam int DW = $clog2(POWERUP_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_COUNT + 1);
    localparam logic [RW-1:0] REF_TOTAL = RW'(REFRESH_COUNT);

    init_state_t   state, state_n;
    logic [RW-1:0] ref_cnt;
    logic          tmr_load, tmr_done;
    logic [DW-1:0] tmr_val;
    sdram_cmd_t    cmd;
    logic [12:0]   addr;

    sdram_nop_timer #(.WIDTH(DW)) u_timer (
        .iclk      (iclk),
        .iload     (tmr_load),
        .iload_val (tmr_val),
        .odone     (tmr_done)
    );

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state   <= ST_WAIT;
            ref_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == ST_REFRESH)
                ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        cmd     = CMD_NOP;
        addr    = '0;
        case (state)
            ST_WAIT:      if (tmr_done) state_n = ST_PRECHARGE;
            ST_PRECHARGE: begin
                cmd     = CMD_PRECHARGE;
                addr    = PRECHARGE_ALL_ADDR;
                state_n = ST_TRP;
            end
            ST_TRP:       if (tmr_done) state_n = ST_REFRESH;
            ST_REFRESH: begin
                cmd     = CMD_REFRESH;
                state_n = ST_TRFC;
            end
            ST_TRFC:      if (tmr_done) state_n = (ref_cnt < REF_TOTAL) ? ST_REFRESH : ST_LOAD;
            ST_LOAD: begin
                cmd     = CMD_LOAD_MODE;
                addr    = MODE_REG;
                state_n = ST_TMRD;
            end
            ST_TMRD:      if (tmr_done) state_n = ST_DONE;
            ST_DONE:      ;
            default:      state_n = ST_WAIT;
        endcase
    end

    // Reset is the WAIT entry: the extra count covers the cycle spent in
    // reset so PRECHARGE lands exactly POWERUP_CYCLES cycles after release.
    always_comb begin
        tmr_load = ireset || (state_n != state);
        tmr_val  = '0;
        if (ireset)
            tmr_val = DW'(POWERUP_CYCLES);
        else
            case (state_n)
                ST_TRP:  tmr_val = DW'(TRP_CYCLES - 1);
                ST_TRFC: tmr_val = DW'(TRFC_CYCLES - 1);
                ST_TMRD: tmr_val = DW'(TMRD_CYCLES - 1);
                default: tmr_val = '0;
            endcase
    end

    assign oinit_fin = (state == ST_DONE);

    assign dram.DRAM_CLK  = iclk;
    assign dram.DRAM_CKE  = 1'b1;
    assign dram.DRAM_ADDR = addr;
    assign dram.DRAM_BA   = 2'b00;
    assign {dram.DRAM_CS_N, dram.DRAM_RAS_N, dram.DRAM_CAS_N, dram.DRAM_WE_N} = cmd;
    assign dram.DRAM_LDQM = 1'b1;
    assign dram.DRAM_UDQM = 1'b1;
endmodule

// File: tb/tb_sdram_init.sv
// Three sequencer configurations checked cycle by cycle against the published
// command schedule, with directed and random resets.
module tb_sdram_init;

    localparam logic [3:0] E_NOP = 4'b0111;
    localparam logic [3:0] E_PRE = 4'b0010;
    localparam logic [3:0] E_REF = 4'b0001;
    localparam logic [3:0] E_LMR = 4'b0000;

    int          pw   [3] = '{5000, 4, 1};
    int          trp  [3] = '{2, 2, 1};
    int          trfc [3] = '{7, 1, 1};
    int          nref [3] = '{2, 8, 2};
    int          tmrd [3] = '{2, 2, 1};
    logic [12:0] mr   [3] = '{13'h0220, 13'h0220, 13'h0231};

    logic        iclk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  o_fin;
    logic [3:0]  o_cmd  [3];
    logic [12:0] o_addr [3];
    logic [5:0]  o_misc [3];

    int t [3];          // cycles since release; -1 just after a reset edge, -2 never reset
    int hold [3];
    int ref_seen [3];
    bit fin_seen [3];
    bit rand_on;
    int checks = 0;
    int errors = 0;

    always #5 iclk = ~iclk;

    sdram_init_if bus_a ();
    sdram_init_if bus_b ();
    sdram_init_if bus_c ();

    sdram_init dut_a (.iclk(iclk), .ireset(rst[0]), .oinit_fin(o_fin[0]), .dram(bus_a));

    sdram_init #(.POWERUP_CYCLES(4), .TRP_CYCLES(2), .TRFC_CYCLES(1), .REFRESH_COUNT(8),
                 .TMRD_CYCLES(2), .MODE_REG(13'h0220))
        dut_b (.iclk(iclk), .ireset(rst[1]), .oinit_fin(o_fin[1]), .dram(bus_b));

    sdram_init #(.POWERUP_CYCLES(1), .TRP_CYCLES(1), .TRFC_CYCLES(1), .REFRESH_COUNT(2),
                 .TMRD_CYCLES(1), .MODE_REG(13'h0231))
        dut_c (.iclk(iclk), .ireset(rst[2]), .oinit_fin(o_fin[2]), .dram(bus_c));

    assign o_cmd[0]  = {bus_a.DRAM_CS_N, bus_a.DRAM_RAS_N, bus_a.DRAM_CAS_N, bus_a.DRAM_WE_N};
    assign o_cmd[1]  = {bus_b.DRAM_CS_N, bus_b.DRAM_RAS_N, bus_b.DRAM_CAS_N, bus_b.DRAM_WE_N};
    assign o_cmd[2]  = {bus_c.DRAM_CS_N, bus_c.DRAM_RAS_N, bus_c.DRAM_CAS_N, bus_c.DRAM_WE_N};
    assign o_addr[0] = bus_a.DRAM_ADDR;
    assign o_addr[1] = bus_b.DRAM_ADDR;
    assign o_addr[2] = bus_c.DRAM_ADDR;
    assign o_misc[0] = {bus_a.DRAM_CKE, bus_a.DRAM_BA, bus_a.DRAM_LDQM, bus_a.DRAM_UDQM, bus_a.DRAM_CLK};
    assign o_misc[1] = {bus_b.DRAM_CKE, bus_b.DRAM_BA, bus_b.DRAM_LDQM, bus_b.DRAM_UDQM, bus_b.DRAM_CLK};
    assign o_misc[2] = {bus_c.DRAM_CKE, bus_c.DRAM_BA, bus_c.DRAM_LDQM, bus_c.DRAM_UDQM, bus_c.DRAM_CLK};

    // Expected {fin, cmd, addr} in cycle tt straight from the timing formulas.
    function automatic logic [17:0] model(input int tt, input int i);
        int r0, ld;
        r0 = pw[i] + 1 + trp[i];
        ld = r0 + nref[i] * (1 + trfc[i]);
        if (tt == pw[i]) return {1'b0, E_PRE, 13'h0400};
        if (tt >= r0 && tt < ld && ((tt - r0) % (1 + trfc[i])) == 0) return {1'b0, E_REF, 13'h0000};
        if (tt == ld) return {1'b0, E_LMR, mr[i]};
        return {(tt >= ld + 1 + tmrd[i]), E_NOP, 13'h0000};
    endfunction

    task automatic chk(input string tag, input int i, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d t=%0d got %h expected %h", tag, i, t[i], got, exp);
        end
    endtask

    task automatic step();
        logic [17:0] e;
        for (int i = 1; i < 3; i++) begin
            if (rand_on && hold[i] == 0 && $urandom_range(63) == 0)
                hold[i] = $urandom_range(3, 1);
            rst[i] = (hold[i] != 0);
            if (hold[i] != 0) hold[i]--;
        end
        @(posedge iclk);
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                t[i]        = -1;
                ref_seen[i] = 0;
                fin_seen[i] = 1'b0;
            end else if (t[i] != -2) begin
                t[i]++;
            end
        end
        @(negedge iclk);
        for (int i = 0; i < 3; i++) begin
            if (t[i] == -2) continue;
            e = model(t[i], i);
            chk("cmd",  i, 13'(o_cmd[i]), 13'(e[16:13]));
            chk("addr", i, o_addr[i], e[12:0]);
            chk("fin",  i, 13'(o_fin[i]), 13'(e[17]));
            chk("pins", i, 13'(o_misc[i]), 13'(6'b1_00_1_1_0));
            if (o_cmd[i] == E_REF) ref_seen[i]++;
            if (o_fin[i] && !fin_seen[i]) begin
                chk("ref_count", i, 13'(ref_seen[i]), 13'(nref[i]));
                fin_seen[i] = 1'b1;
            end
        end
    endtask

    initial begin
        t        = '{-2, -2, -2};
        hold     = '{0, 3, 3};
        ref_seen = '{0, 0, 0};
        fin_seen = '{0, 0, 0};
        rand_on  = 1'b0;
        rst      = 3'b111;

        repeat (3) step();
        rst[0] = 1'b0;
        repeat (60) step();              // small configs run a clean sequence to DONE
        rand_on = 1'b1;

        repeat (5005 - t[0]) step();     // dut_a sits in TRFC after its first refresh
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;

        repeat (5030 - t[0]) step();     // dut_a in DONE
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;

        repeat (5030 - t[0]) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
